// File: rtl/sprite_layer_compositor_if.sv
// rtl/sprite_layer_compositor_if.sv - pixel, fade control and palette bus of the sprite layer compositor
interface sprite_layer_compositor_if #(
  parameter int NUM_LAYERS = 8,
  parameter int IDX_W      = 4,
  parameter int FADE_W     = 4
);
  localparam int PAL_AW = $clog2(NUM_LAYERS + 1) + IDX_W;

  logic                        pix_valid;
  logic [NUM_LAYERS*IDX_W-1:0] layer_idx;
  logic [NUM_LAYERS-1:0]       layer_en;
  logic [NUM_LAYERS-1:0]       layer_blink;
  logic [IDX_W-1:0]            bg_idx;
  logic                        frame_start;
  logic                        fade_req;
  logic                        fade_dir;
  logic                        pal_we;
  logic [PAL_AW-1:0]           pal_addr;
  logic [23:0]                 pal_data;
  logic [7:0]                  vga_r;
  logic [7:0]                  vga_g;
  logic [7:0]                  vga_b;
  logic                        out_valid;
  logic                        fade_busy;
  logic [FADE_W:0]             fade_level;

  modport master (
    output pix_valid, layer_idx, layer_en, layer_blink, bg_idx, frame_start,
           fade_req, fade_dir, pal_we, pal_addr, pal_data,
    input  vga_r, vga_g, vga_b, out_valid, fade_busy, fade_level
  );

  modport slave (
    input  pix_valid, layer_idx, layer_en, layer_blink, bg_idx, frame_start,
           fade_req, fade_dir, pal_we, pal_addr, pal_data,
    output vga_r, vga_g, vga_b, out_valid, fade_busy, fade_level
  );
endinterface

// File: rtl/sprite_layer_compositor.sv
// rtl/sprite_layer_compositor.sv - priority/transparency resolve, palette lookup, blink and fade
// Three-stage pixel pipeline: resolve winner, palette read, fade scaling.
module sprite_layer_compositor #(
  parameter int NUM_LAYERS      = 8,
  parameter int IDX_W           = 4,
  parameter int TRANSPARENT_IDX = 0,
  parameter int FADE_W          = 4,
  parameter int FADE_RATE       = 2,
  parameter int BLINK_SHIFT     = 3
) (
  input logic clk,
  input logic rst,
  sprite_layer_compositor_if.slave bus
);
  localparam int PN_W   = $clog2(NUM_LAYERS + 1);
  localparam int PAL_AW = PN_W + IDX_W;
  localparam int CNT_W  = $clog2(FADE_RATE + 1);
  localparam int PROD_W = 9 + FADE_W;
  localparam logic [FADE_W:0] LEVEL_MAX = {1'b1, {FADE_W{1'b0}}};
  localparam logic [FADE_W:0] LEVEL_TOP = LEVEL_MAX - 1'b1;
  localparam logic [FADE_W:0] LEVEL_ONE = {{FADE_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {FULL, FADE_OUT, BLACK, FADE_IN} fade_state_t;

  fade_state_t        state, state_n;
  logic [FADE_W:0]    level, level_n;
  logic [CNT_W-1:0]   fcnt, fcnt_n;
  logic [BLINK_SHIFT:0] blink_cnt;

  logic [PN_W-1:0]    win_pal;
  logic [IDX_W-1:0]   win_idx;
  logic               s1_valid, s2_valid, s3_valid;
  logic [PAL_AW-1:0]  s1_addr;
  logic [23:0]        rd_data;
  logic [7:0]         fade_r, fade_g, fade_b;
  logic [7:0]         out_r, out_g, out_b;

  logic [23:0]        pal_mem [0:2**PAL_AW-1];
  logic               wr_pend;
  logic [PAL_AW-1:0]  wr_addr;
  logic [23:0]        wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_cnt <= '0;
    else if (bus.frame_start) blink_cnt <= blink_cnt + 1'b1;
  end

  // Scan from lowest priority upward so the last hit is the highest-priority layer.
  always_comb begin
    win_pal = PN_W'(NUM_LAYERS);
    win_idx = bus.bg_idx;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (bus.layer_en[i] &&
          bus.layer_idx[i*IDX_W +: IDX_W] != IDX_W'(TRANSPARENT_IDX) &&
          !(bus.layer_blink[i] && blink_cnt[BLINK_SHIFT])) begin
        win_pal = PN_W'(i);
        win_idx = bus.layer_idx[i*IDX_W +: IDX_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= bus.pix_valid;
      s1_addr  <= {win_pal, win_idx};
    end
  end

  // Writes land one edge late so a pixel sampled alongside a write still reads the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_pend <= 1'b0;
    else     wr_pend <= bus.pal_we;
  end

  always_ff @(posedge clk) begin
    wr_addr <= bus.pal_addr;
    wr_data <= bus.pal_data;
  end

  always_ff @(posedge clk) begin
    if (wr_pend) pal_mem[wr_addr] <= wr_data;
    rd_data <= pal_mem[s1_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s2_valid <= 1'b0;
    else     s2_valid <= s1_valid;
  end

  assign fade_r = 8'((PROD_W'(rd_data[23:16]) * PROD_W'(level)) >> FADE_W);
  assign fade_g = 8'((PROD_W'(rd_data[15:8])  * PROD_W'(level)) >> FADE_W);
  assign fade_b = 8'((PROD_W'(rd_data[7:0])   * PROD_W'(level)) >> FADE_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid <= 1'b0;
      out_r    <= '0;
      out_g    <= '0;
      out_b    <= '0;
    end else begin
      s3_valid <= s2_valid;
      out_r    <= s2_valid ? fade_r : 8'h00;
      out_g    <= s2_valid ? fade_g : 8'h00;
      out_b    <= s2_valid ? fade_b : 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FULL;
      level <= LEVEL_MAX;
      fcnt  <= '0;
    end else begin
      state <= state_n;
      level <= level_n;
      fcnt  <= fcnt_n;
    end
  end

  // A request accepted in the same cycle as frame_start resets the frame count, so that pulse is not a step.
  always_comb begin
    state_n = state;
    level_n = level;
    fcnt_n  = fcnt;
    case (state)
      FULL: if (bus.fade_req && !bus.fade_dir) begin
        state_n = FADE_OUT;
        fcnt_n  = '0;
      end
      BLACK: if (bus.fade_req && bus.fade_dir) begin
        state_n = FADE_IN;
        fcnt_n  = '0;
      end
      FADE_OUT: if (bus.frame_start) begin
        if (fcnt == CNT_W'(FADE_RATE - 1)) begin
          fcnt_n  = '0;
          level_n = level - 1'b1;
          if (level == LEVEL_ONE) state_n = BLACK;
        end else begin
          fcnt_n = fcnt + 1'b1;
        end
      end
      FADE_IN: if (bus.frame_start) begin
        if (fcnt == CNT_W'(FADE_RATE - 1)) begin
          fcnt_n  = '0;
          level_n = level + 1'b1;
          if (level == LEVEL_TOP) state_n = FULL;
        end else begin
          fcnt_n = fcnt + 1'b1;
        end
      end
      default: state_n = FULL;
    endcase
  end

  assign bus.vga_r      = out_r;
  assign bus.vga_g      = out_g;
  assign bus.vga_b      = out_b;
  assign bus.out_valid  = s3_valid;
  assign bus.fade_busy  = (state == FADE_OUT) || (state == FADE_IN);
  assign bus.fade_level = level;
endmodule

// File: tb/tb_sprite_layer_compositor.sv
// tb/tb_sprite_layer_compositor.sv - randomized scoreboard bench for sprite_layer_compositor
module tb_sprite_layer_compositor;
  localparam int NL  = 8;
  localparam int IW  = 4;
  localparam int FW  = 4;
  localparam int FR  = 2;
  localparam int BS  = 3;
  localparam int PAW = $clog2(NL + 1) + IW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_layer_compositor_if #(.NUM_LAYERS(NL), .IDX_W(IW), .FADE_W(FW)) bus ();

  sprite_layer_compositor #(
    .NUM_LAYERS(NL), .IDX_W(IW), .TRANSPARENT_IDX(0),
    .FADE_W(FW), .FADE_RATE(FR), .BLINK_SHIFT(BS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [23:0] rgb;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [23:0] pal_m [0:NL][0:(1<<IW)-1];
  int          blink_m;
  int          lvl_m;
  int          fcnt_m;
  int          fst_m;  // 0 full, 1 fading out, 2 black, 3 fading in

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit busy_m();
    return (fst_m == 1) || (fst_m == 3);
  endfunction

  function automatic logic [23:0] ref_pixel(input logic [NL*IW-1:0] idx, input logic [NL-1:0] en,
                                            input logic [NL-1:0] blink, input logic [IW-1:0] bg);
    int pn, ix;
    logic [23:0] c;
    pn = NL;
    ix = int'(bg);
    for (int i = 0; i < NL; i++) begin
      if (en[i] && idx[i*IW +: IW] != 0 && !(blink[i] && blink_m >= (1 << BS))) begin
        pn = i;
        ix = int'(idx[i*IW +: IW]);
        break;
      end
    end
    c = pal_m[pn][ix];
    return {8'((int'(c[23:16]) * lvl_m) >> FW),
            8'((int'(c[15:8])  * lvl_m) >> FW),
            8'((int'(c[7:0])   * lvl_m) >> FW)};
  endfunction

  task automatic fade_model(input logic fs, input logic req, input logic dir);
    if (req && ((fst_m == 0 && !dir) || (fst_m == 2 && dir))) begin
      fst_m  = dir ? 3 : 1;
      fcnt_m = 0;
    end else if (fs && busy_m()) begin
      fcnt_m++;
      if (fcnt_m == FR) begin
        fcnt_m = 0;
        lvl_m += (fst_m == 3) ? 1 : -1;
        if (lvl_m == 0) fst_m = 2;
        if (lvl_m == (1 << FW)) fst_m = 0;
      end
    end
  endtask

  task automatic model_reset();
    blink_m = 0;
    lvl_m   = 1 << FW;
    fcnt_m  = 0;
    fst_m   = 0;
    sbq.delete();
  endtask

  task automatic idle_inputs();
    bus.pix_valid = 1'b0; bus.layer_idx = '0; bus.layer_en = '0; bus.layer_blink = '0;
    bus.bg_idx = '0; bus.frame_start = 1'b0; bus.fade_req = 1'b0; bus.fade_dir = 1'b0;
    bus.pal_we = 1'b0; bus.pal_addr = '0; bus.pal_data = '0;
  endtask

  task automatic step(input logic pv, input logic [NL*IW-1:0] idx, input logic [NL-1:0] en,
                      input logic [NL-1:0] blink, input logic [IW-1:0] bg,
                      input logic fs = 1'b0, input logic req = 1'b0, input logic dir = 1'b0,
                      input logic we = 1'b0, input logic [PAW-1:0] wa = '0, input logic [23:0] wd = '0);
    @(negedge clk);
    if (!rst) begin
      check("fade_level", 32'(bus.fade_level), 32'(lvl_m));
      check("fade_busy", 32'(bus.fade_busy), 32'(busy_m()));
    end
    bus.pix_valid = pv; bus.layer_idx = idx; bus.layer_en = en; bus.layer_blink = blink;
    bus.bg_idx = bg; bus.frame_start = fs; bus.fade_req = req; bus.fade_dir = dir;
    bus.pal_we = we; bus.pal_addr = wa; bus.pal_data = wd;
    if (pv) sbq.push_back('{ref_pixel(idx, en, blink, bg), cyc + 3});
    if (we) pal_m[int'(wa >> IW)][int'(wa[IW-1:0])] = wd;
    fade_model(fs, req, dir);
    if (fs) blink_m = (blink_m + 1) % (1 << (BS + 1));
  endtask

  task automatic pal_wr(input int pn, input int ix, input logic [23:0] d);
    step(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, PAW'(pn * (1 << IW) + ix), d);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() > 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("queue_drained", 32'(sbq.size()), 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          check("pixel_expected", 32'(sbq.size()), 32'd1);
        end else begin
          e = sbq.pop_front();
          check("pixel_rgb", {8'h00, bus.vga_r, bus.vga_g, bus.vga_b}, {8'h00, e.rgb});
          check("pixel_latency", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  initial begin : stimulus
    logic [NL*IW-1:0] v;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_rgb", {8'h00, bus.vga_r, bus.vga_g, bus.vga_b}, 32'd0);
    check("rst_fade_busy", 32'(bus.fade_busy), 32'd0);
    check("rst_fade_level", 32'(bus.fade_level), 32'(1 << FW));
    rst = 1'b0;

    for (int pn = 0; pn <= NL; pn++)
      for (int ix = 0; ix < (1 << IW); ix++)
        pal_wr(pn, ix, 24'($urandom()));
    pal_wr(1, 5, 24'hFF0000);
    pal_wr(8, 0, 24'h123456);
    pal_wr(0, 1, 24'hFF8040);
    pal_wr(0, 4, 24'hAAAAAA);
    pal_wr(1, 4, 24'h555555);
    nop(2);

    // priority and transparency, then background fallback
    v = '0; v[1*IW +: IW] = 4'd5; v[3*IW +: IW] = 4'd7;
    step(1'b1, v, 8'hFF, '0, 4'd2);
    step(1'b1, v, 8'hFD, '0, 4'd2);
    step(1'b1, '0, 8'hFF, '0, 4'd0);
    v = NL*IW'($urandom());
    step(1'b1, v, 8'h00, '0, 4'd0);
    nop(4);

    for (int i = 0; i < 400; i++) begin
      v = NL*IW'($urandom());
      step($urandom_range(0, 3) != 0, v, NL'($urandom_range(0, 255)), NL'($urandom_range(0, 255)),
           IW'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
    end
    drain();

    // blink over 17 frames from a freshly reset counter
    do_reset();
    v = '0; v[0 +: IW] = 4'd4; v[IW +: IW] = 4'd4;
    for (int f = 0; f <= 16; f++) begin
      step(1'b1, v, 8'h03, 8'h01, 4'd0);
      step(1'b0, '0, '0, '0, '0, 1'b1);
    end
    nop(3);

    // read-first: the pixel beside the write sees the old entry
    pal_wr(0, 3, 24'h0A0B0C);
    nop(1);
    v = '0; v[0 +: IW] = 4'd3;
    step(1'b1, v, 8'h01, '0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, PAW'(3), 24'hC0FFEE);
    step(1'b0, '0, '0, '0, '0);
    step(1'b1, v, 8'h01, '0, 4'd0);
    nop(3);

    // fade out with an ignored request while busy
    v = '0; v[0 +: IW] = 4'd1;
    step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int f = 1; f <= 32; f++) begin
      step(1'b0, '0, '0, '0, '0, 1'b1, f == 5, 1'b0);
      step(1'b1, v, 8'h01, '0, 4'd0);
      if (f == 2) check("fade_second_frame_level", 32'(bus.fade_level), 32'd15);
      nop(2);
    end
    check("fade_out_level", 32'(bus.fade_level), 32'd0);
    check("fade_out_busy", 32'(bus.fade_busy), 32'd0);

    // fade in, requested together with a frame_start
    step(1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 1'b1);
    for (int f = 1; f <= 32; f++) begin
      step(1'b0, '0, '0, '0, '0, 1'b1);
      step(1'b1, v, 8'h01, '0, 4'd0);
      nop(2);
    end
    check("fade_in_level", 32'(bus.fade_level), 32'(1 << FW));
    check("fade_in_busy", 32'(bus.fade_busy), 32'd0);

    // asynchronous reset in the middle of a fade
    step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int f = 0; f < 40 && lvl_m > 9; f++) begin
      step(1'b0, '0, '0, '0, '0, 1'b1);
      step(1'b0, '0, '0, '0, '0);
    end
    step(1'b1, v, 8'h01, '0, 4'd0);
    nop(2);
    @(negedge clk);
    #2;
    check("pre_reset_level", 32'(bus.fade_level), 32'd9);
    check("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_level", 32'(bus.fade_level), 32'(1 << FW));
    check("async_rst_busy", 32'(bus.fade_busy), 32'd0);
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_rgb", {8'h00, bus.vga_r, bus.vga_g, bus.vga_b}, 32'd0);
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, v, 8'h01, '0, 4'd0);
    step(1'b1, '0, 8'h00, '0, 4'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
